vga_frame_reader: RTL and testbench

Display-side reader of the video frame buffer. The CPU writes 3-bit pixels into a 256x256 buffer with its VGA instruction. This block scans that buffer in raster order, generates 640x480@60 Hz VGA timing, and drives registered RGB and sync pins. It sits between the dual-port video RAM's read port and the board VGA connector.

---
 rtl/vga_defs.sv | 38 +++
 rtl/vga_timing_counter.sv | 56 +++++
 rtl/vga_frame_reader.sv | 128 ++++++++++++
 tb/tb_vga_frame_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_defs.sv
// Shared VGA 640x480@60 timing constants, colour codes and frame-buffer geometry
// used by the frame-buffer reader and its timing generator.
package vga_defs;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int BUF_DIM = 256;

  typedef logic [2:0] rgb_t;

  localparam rgb_t COLOR_BLACK = 3'b000;
  localparam rgb_t COLOR_RED   = 3'b100;
  localparam rgb_t COLOR_GREEN = 3'b010;
  localparam rgb_t COLOR_BLUE  = 3'b001;
  localparam rgb_t COLOR_WHITE = 3'b111;

  // Half-open range test lo <= x < hi on counter-width values.
  function automatic logic in_range(input logic [9:0] x, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-enable divider and raster H/V counters with raw (unregistered) sync,
// visible and vertical-blank flags for the current counter value.
module vga_timing_counter
  import vga_defs::*;
(
  input  logic       Clock,
  input  logic       Reset,
  output logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible_raw,
  output logic       vblank_raw
);

  logic       en_q, en_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    en_d = ~en_q;
    h_d  = h_q;
    v_d  = v_q;
    if (en_q) begin
      if (h_q == H_TOTAL - 10'd1) begin
        h_d = '0;
        v_d = (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Stage 0: counters
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      en_q <= 1'b0;
      h_q  <= '0;
      v_q  <= '0;
    end else begin
      en_q <= en_d;
      h_q  <= h_d;
      v_q  <= v_d;
    end
  end

  assign pix_en      = en_q;
  assign h           = h_q;
  assign v           = v_q;
  assign hsync_raw   = ~in_range(h_q, H_SYNC_START, H_SYNC_END);
  assign vsync_raw   = ~in_range(v_q, V_SYNC_START, V_SYNC_END);
  assign visible_raw = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
  assign vblank_raw  = (v_q >= V_VISIBLE);

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the 256x256 video buffer in raster order inside a centred window and
// drives registered VGA colour and sync pins with a two-pixel pipeline.
module vga_frame_reader
  import vga_defs::*;
#(
  parameter int H_OFFSET = 192,
  parameter int V_OFFSET = 112
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  iReadData,
  output logic [15:0] oReadAddress,
  output logic        oRed,
  output logic        oGreen,
  output logic        oBlue,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oVBlank
);

  localparam logic [9:0] WIN_H_LO = 10'(H_OFFSET);
  localparam logic [9:0] WIN_H_HI = 10'(H_OFFSET + BUF_DIM);
  localparam logic [9:0] WIN_V_LO = 10'(V_OFFSET);
  localparam logic [9:0] WIN_V_HI = 10'(V_OFFSET + BUF_DIM);

  logic       pix_en;
  logic [9:0] h, v;
  logic       hsync_raw, vsync_raw, visible_raw, vblank_raw;

  vga_timing_counter u_timing (
    .Clock       (Clock),
    .Reset       (Reset),
    .pix_en      (pix_en),
    .h           (h),
    .v           (v),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .visible_raw (visible_raw),
    .vblank_raw  (vblank_raw)
  );

  logic       in_win;
  logic [7:0] col, row;

  always_comb begin
    in_win = visible_raw && in_range(h, WIN_H_LO, WIN_H_HI)
                         && in_range(v, WIN_V_LO, WIN_V_HI);
    col    = 8'(h - WIN_H_LO);
    row    = 8'(v - WIN_V_LO);
  end

  logic [15:0] addr_p1_q, addr_p1_d;
  logic        vld_p1_q, vld_p1_d;
  logic        hs_p1_q, hs_p1_d;
  logic        vs_p1_q, vs_p1_d;
  logic        vb_p1_q, vb_p1_d;

  rgb_t        rgb_p2_q, rgb_p2_d;
  logic        hs_p2_q, hs_p2_d;
  logic        vs_p2_q, vs_p2_d;
  logic        vb_p2_q, vb_p2_d;

  always_comb begin
    addr_p1_d = addr_p1_q;
    vld_p1_d  = vld_p1_q;
    hs_p1_d   = hs_p1_q;
    vs_p1_d   = vs_p1_q;
    vb_p1_d   = vb_p1_q;
    rgb_p2_d  = rgb_p2_q;
    hs_p2_d   = hs_p2_q;
    vs_p2_d   = vs_p2_q;
    vb_p2_d   = vb_p2_q;
    if (pix_en) begin
      // Address only advances inside the window; outside it the RAM output is masked.
      if (in_win) addr_p1_d = {row, col};
      vld_p1_d = in_win;
      hs_p1_d  = hsync_raw;
      vs_p1_d  = vsync_raw;
      vb_p1_d  = vblank_raw;
      // RAM data for addr_p1_q has settled one Clock before this enabled edge.
      rgb_p2_d = vld_p1_q ? rgb_t'(iReadData) : COLOR_BLACK;
      hs_p2_d  = hs_p1_q;
      vs_p2_d  = vs_p1_q;
      vb_p2_d  = vb_p1_q;
    end
  end

  // Stage 1: read address and delayed window/sync flags
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      vb_p1_q   <= 1'b0;
    end else begin
      addr_p1_q <= addr_p1_d;
      vld_p1_q  <= vld_p1_d;
      hs_p1_q   <= hs_p1_d;
      vs_p1_q   <= vs_p1_d;
      vb_p1_q   <= vb_p1_d;
    end
  end

  // Stage 2: colour and syncs registered together at the pins
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rgb_p2_q <= COLOR_BLACK;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
      vb_p2_q  <= 1'b0;
    end else begin
      rgb_p2_q <= rgb_p2_d;
      hs_p2_q  <= hs_p2_d;
      vs_p2_q  <= vs_p2_d;
      vb_p2_q  <= vb_p2_d;
    end
  end

  assign oReadAddress = addr_p1_q;
  assign oRed         = rgb_p2_q[2];
  assign oGreen       = rgb_p2_q[1];
  assign oBlue        = rgb_p2_q[0];
  assign oHSync       = hs_p2_q;
  assign oVSync       = vs_p2_q;
  assign oVBlank      = vb_p2_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: a synchronous RAM model feeds the reader;
// the raster counter is jumped to regions of interest to keep runs short.
module tb_vga_frame_reader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  iReadData = 3'b000;
  logic [15:0] oReadAddress;
  logic        oRed, oGreen, oBlue, oHSync, oVSync, oVBlank;

  vga_frame_reader dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iReadData    (iReadData),
    .oReadAddress (oReadAddress),
    .oRed         (oRed),
    .oGreen       (oGreen),
    .oBlue        (oBlue),
    .oHSync       (oHSync),
    .oVSync       (oVSync),
    .oVBlank      (oVBlank)
  );

  always #10 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int cyc;
  int delta = 0;
  int ram_mode = 0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = 16'h0000;
  logic [2:0]  wr_data = 3'b000;
  logic [9:0]  jh, jv;

  function automatic logic [2:0] ram_val(input logic [15:0] a);
    if (wr_en && a == wr_addr) return wr_data;
    if (ram_mode == 0) return 3'b010;
    return a[2:0];
  endfunction

  always @(posedge Clock) iReadData <= ram_val(oReadAddress);

  always @(posedge Clock or negedge Reset)
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic int pix(input int v, input int h);
    return v * 800 + h;
  endfunction

  task automatic wait_cyc(input int target, input string tag);
    int guard = 0;
    while (cyc < target && guard < 60000) begin
      @(negedge Clock);
      guard++;
    end
    if (cyc != target) begin
      checks++; failures++;
      $display("FAIL wait_%s cycle=%0d required=%0d", tag, cyc, target);
    end
  endtask

  task automatic goto_out(input int p);
    wait_cyc(2 * (p - delta + 2), "out");
  endtask

  task automatic goto_addr(input int p);
    wait_cyc(2 * (p - delta + 1), "addr");
  endtask

  // Move the raster counter to (v,h) right after an enabled edge.
  task automatic jump(input int v, input int h);
    if (cyc % 2 != 0) @(negedge Clock);
    jv = 10'(v);
    jh = 10'(h);
    force dut.u_timing.h_q = jh;
    force dut.u_timing.v_q = jv;
    #1;
    release dut.u_timing.h_q;
    release dut.u_timing.v_q;
    delta = pix(v, h) - cyc / 2;
  endtask

  task automatic chk_rgb(input string name, input logic [2:0] exp);
    checks++;
    if ({oRed, oGreen, oBlue} !== exp) begin
      failures++;
      $display("FAIL %s rgb=%b required=%b", name, {oRed, oGreen, oBlue}, exp);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (oReadAddress !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h required=0000", oReadAddress); end
    chk_rgb("rst_rgb", 3'b000);
    checks++; if (oHSync !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%b required=1", oHSync); end
    checks++; if (oVSync !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%b required=1", oVSync); end
    checks++; if (oVBlank !== 1'b0) begin failures++; $display("FAIL rst_vblank got=%b required=0", oVBlank); end
    Reset = 1'b1;
    delta = 0;
  endtask

  task automatic test_hsync;
    int lows = 0;
    int lit = 0;
    ram_mode = 0;
    goto_out(pix(0, 0));
    for (int i = 0; i < 1600; i++) begin
      if (oHSync === 1'b0) lows++;
      if ({oRed, oGreen, oBlue} !== 3'b000) lit++;
      @(negedge Clock);
    end
    checks++; if (lows !== 192) begin failures++; $display("FAIL hsync_low_clocks got=%0d required=192", lows); end
    checks++; if (lit !== 0) begin failures++; $display("FAIL line0_dark lit=%0d required=0", lit); end
    goto_out(pix(1, 655));
    checks++; if (oHSync !== 1'b1) begin failures++; $display("FAIL hsync_655 got=%b required=1", oHSync); end
    goto_out(pix(1, 656));
    checks++; if (oHSync !== 1'b0) begin failures++; $display("FAIL hsync_656 got=%b required=0", oHSync); end
    goto_out(pix(1, 751));
    checks++; if (oHSync !== 1'b0) begin failures++; $display("FAIL hsync_751 got=%b required=0", oHSync); end
    goto_out(pix(1, 752));
    checks++; if (oHSync !== 1'b1) begin failures++; $display("FAIL hsync_752 got=%b required=1", oHSync); end
  endtask

  task automatic test_green;
    int greens = 0;
    int other = 0;
    ram_mode = 0;
    jump(111, 200);
    goto_out(pix(111, 300));
    chk_rgb("green_row111", 3'b000);
    goto_out(pix(112, 0));
    for (int i = 0; i < 1600; i++) begin
      if (oGreen === 1'b1) greens++;
      if (oRed !== 1'b0 || oBlue !== 1'b0) other++;
      @(negedge Clock);
    end
    checks++; if (greens !== 512) begin failures++; $display("FAIL green_row112_clocks got=%0d required=512", greens); end
    checks++; if (other !== 0) begin failures++; $display("FAIL green_row112_rb got=%0d required=0", other); end
    goto_out(pix(113, 191)); chk_rgb("green_h191", 3'b000);
    goto_out(pix(113, 192)); chk_rgb("green_h192", 3'b010);
    goto_out(pix(113, 447)); chk_rgb("green_h447", 3'b010);
    goto_out(pix(113, 448)); chk_rgb("green_h448", 3'b000);
  endtask

  task automatic test_address;
    ram_mode = 1;
    jump(112, 180);
    goto_addr(pix(112, 192));
    checks++; if (oReadAddress !== 16'h0000) begin failures++; $display("FAIL addr_first got=%h required=0000", oReadAddress); end
    for (int h = 192; h < 208; h++) begin
      goto_out(pix(112, h));
      chk_rgb("addr_seq", 3'(h - 192));
    end
    goto_addr(pix(113, 200));
    checks++; if (oReadAddress !== 16'h0108) begin failures++; $display("FAIL addr_r1c8 got=%h required=0108", oReadAddress); end
    jump(367, 440);
    goto_addr(pix(367, 447));
    checks++; if (oReadAddress !== 16'hFFFF) begin failures++; $display("FAIL addr_last got=%h required=ffff", oReadAddress); end
    goto_out(pix(367, 447)); chk_rgb("addr_last_rgb", 3'b111);
    goto_out(pix(367, 448)); chk_rgb("addr_past_col", 3'b000);
    goto_out(pix(368, 192)); chk_rgb("addr_past_row", 3'b000);
  endtask

  task automatic test_wrap;
    int vlows = 0;
    ram_mode = 0;
    jump(479, 790);
    goto_out(pix(479, 799));
    checks++; if (oVBlank !== 1'b0) begin failures++; $display("FAIL vblank_479 got=%b required=0", oVBlank); end
    goto_out(pix(480, 0));
    checks++; if (oVBlank !== 1'b1) begin failures++; $display("FAIL vblank_480 got=%b required=1", oVBlank); end
    chk_rgb("blank_rgb", 3'b000);
    jump(489, 790);
    goto_out(pix(489, 798));
    for (int i = 0; i < 3300; i++) begin
      if (oVSync === 1'b0) vlows++;
      @(negedge Clock);
    end
    checks++; if (vlows !== 3200) begin failures++; $display("FAIL vsync_low_clocks got=%0d required=3200", vlows); end
    jump(524, 790);
    goto_out(pix(524, 799));
    checks++; if (oVBlank !== 1'b1) begin failures++; $display("FAIL vblank_524 got=%b required=1", oVBlank); end
    goto_out(pix(525, 0));
    checks++; if (oVBlank !== 1'b0) begin failures++; $display("FAIL vblank_wrap got=%b required=0", oVBlank); end
    checks++; if (oVSync !== 1'b1) begin failures++; $display("FAIL vsync_wrap got=%b required=1", oVSync); end
    goto_out(pix(525, 656));
    checks++; if (oHSync !== 1'b0) begin failures++; $display("FAIL hsync_after_wrap got=%b required=0", oHSync); end
  endtask

  task automatic test_write;
    ram_mode = 0;
    wr_addr = 16'h4020;
    wr_data = 3'b100;
    wr_en = 1'b1;
    jump(176, 200);
    goto_out(pix(176, 223)); chk_rgb("write_h223", 3'b010);
    goto_out(pix(176, 224)); chk_rgb("write_h224", 3'b100);
    goto_out(pix(176, 225)); chk_rgb("write_h225", 3'b010);
    wr_en = 1'b0;
  endtask

  task automatic test_reset_midframe;
    ram_mode = 1;
    jump(200, 290);
    goto_out(pix(200, 300));
    chk_rgb("mid_before", 3'b100);
    #2 Reset = 1'b0;
    #1;
    checks++; if (oReadAddress !== 16'h0000) begin failures++; $display("FAIL mid_addr got=%h required=0000", oReadAddress); end
    chk_rgb("mid_rgb", 3'b000);
    checks++; if (oHSync !== 1'b1 || oVSync !== 1'b1 || oVBlank !== 1'b0) begin
      failures++; $display("FAIL mid_syncs got=%b%b%b required=110", oHSync, oVSync, oVBlank);
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    delta = 0;
    goto_out(pix(0, 655));
    checks++; if (oHSync !== 1'b1) begin failures++; $display("FAIL mid_hsync_655 got=%b required=1", oHSync); end
    goto_out(pix(0, 656));
    checks++; if (oHSync !== 1'b0) begin failures++; $display("FAIL mid_hsync_656 got=%b required=0", oHSync); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_green();
    test_address();
    test_wrap();
    test_write();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
